temp_sample_logger: RTL

- Parametrised successor of the die-temperature capture path.
- Takes the modular ADC response stream and keeps one selected channel, sampling it on an internal programmable interval.
- Subtracts a calibration offset with saturation and stores samples in an internal buffer.
- Two modes: batch (fill to a watermark, then drain to empty) and ring (continuous, overwrite oldest).
- Tracks min, max and latest values; sits between adc_qsys and the BCD/seg7 display path.

---
 rtl/temp_sample_logger.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/temp_sample_logger.sv
// Die-temperature sample logger: filters one ADC channel at a programmable interval,
// removes a calibration offset and buffers samples in batch or ring mode.
module temp_sample_logger #(
  parameter int DATA_W     = 12,
  parameter int OUT_W      = 9,
  parameter int DEPTH      = 32,
  parameter int FILL_LEVEL = 30,
  parameter int INTERVAL   = 5000000,
  parameter int CHANNEL    = 17,
  parameter int OFFSET     = 3431
) (
  input  logic                         clock_in,
  input  logic                         reset_n,
  input  logic                         mode,
  input  logic                         clear,
  input  logic                         adc_valid,
  input  logic [4:0]                   adc_channel,
  input  logic [DATA_W-1:0]            adc_data,
  input  logic                         rd_req,
  output logic [OUT_W-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic [1:0]                   state,
  output logic                         overflow,
  output logic [OUT_W-1:0]             latest,
  output logic [OUT_W-1:0]             min_val,
  output logic [OUT_W-1:0]             max_val,
  output logic                         blip
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(INTERVAL);
  localparam logic [LW-1:0]     DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0]     FILL_L  = LW'(FILL_LEVEL);
  localparam logic [CW-1:0]     CNT_MAX = CW'(INTERVAL-1);
  localparam logic [DATA_W-1:0] OFF     = DATA_W'(OFFSET);
  localparam logic [DATA_W-1:0] SAT     = DATA_W'((1 << OUT_W) - 1);
  localparam logic [4:0]        CH      = 5'(CHANNEL);

  typedef enum logic [1:0] {
    ST_FILL  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_RING  = 2'b10
  } state_t;

  state_t              r_state;
  logic [OUT_W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [LW-1:0]       r_level;
  logic [CW-1:0]       r_cnt;
  logic                r_pending;
  logic                r_overflow;
  logic [OUT_W-1:0]    r_rd_data, r_latest, r_min, r_max;
  logic                r_rd_valid, r_blip;

  logic                w_accept, w_full, w_empty, w_pop, w_wr, w_ovwr, w_wrap;
  logic [DATA_W-1:0]   w_diff;
  logic [OUT_W-1:0]    w_val;

  assign w_accept = r_pending & adc_valid & (adc_channel == CH);
  assign w_diff   = adc_data - OFF;
  assign w_full   = (r_level == DEPTH_L);
  assign w_empty  = (r_level == '0);
  assign w_pop    = rd_req & ~w_empty & (r_state != ST_FILL);
  assign w_wr     = w_accept & (r_state != ST_DRAIN);
  // A full ring with no pop this cycle must drop its oldest entry to make room
  assign w_ovwr   = w_wr & w_full & ~w_pop & (r_state == ST_RING);
  assign w_wrap   = (r_cnt == CNT_MAX);

  always_comb begin
    w_val = '0;
    if (adc_data >= OFF) w_val = (w_diff > SAT) ? '1 : w_diff[OUT_W-1:0];
  end

  always_ff @(posedge clock_in) begin
    if (w_wr && !clear) r_mem[r_wptr] <= w_val;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= mode ? ST_RING : ST_FILL;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_latest   <= '0;
      r_min      <= '1;
      r_max      <= '0;
      r_blip     <= 1'b0;
    end else if (clear) begin
      r_state    <= mode ? ST_RING : ST_FILL;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_min      <= '1;
      r_max      <= '0;
    end else begin
      r_cnt      <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap)        r_pending <= 1'b1;
      else if (w_accept) r_pending <= 1'b0;

      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= r_mem[r_rptr];

      if (w_accept) begin
        r_latest <= w_val;
        r_blip   <= ~r_blip;
        if (w_val < r_min) r_min <= w_val;
        if (w_val > r_max) r_max <= w_val;
      end

      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_pop || w_ovwr) r_rptr <= r_rptr + AW'(1);

      case ({w_wr & ~w_ovwr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      case (r_state)
        ST_FILL: begin
          if (w_wr && (r_level + LW'(1) == FILL_L)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_accept) r_overflow <= 1'b1;
          if (w_pop && (r_level == LW'(1))) r_state <= ST_FILL;
        end
        ST_RING: begin
          if (w_ovwr) r_overflow <= 1'b1;
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign level    = r_level;
  assign full     = w_full;
  assign empty    = w_empty;
  assign state    = r_state;
  assign overflow = r_overflow;
  assign latest   = r_latest;
  assign min_val  = r_min;
  assign max_val  = r_max;
  assign blip     = r_blip;

endmodule
